axi_protocol_checker: RTL
=========================

# axi_protocol_checker

Synthesizable, passive AXI3 protocol checker that observes all five channels of one AXI link and reports violations through sticky error flags, a per-event pulse, a saturating event counter and a first-error code. It sits beside a master/slave pair in the slave environment as the hardware successor of the interface-level assertion set. It adds:
- parametrised widths;
- handshake timeouts;
- outstanding-transaction tracking;
- burst-length checks on write data and read data.

Responses are checked in order; ID-based reordering is not checked.

## Interface
Parameters:
- ID_W, 4, AWID/WID/BID/ARID/RID width
- ADDR_W, 32, AWADDR/ARADDR width
- DATA_W, 32, WDATA/RDATA width; WSTRB is DATA_W/8
- LEN_W, 4, AWLEN/ARLEN width (AXI3)
- MAX_OUT, 8, outstanding-burst FIFO depth per direction (power of 2)
- TIMEOUT, 256, VALID-without-READY cycle limit; 0 disables timeout checks
- CNT_W, 16, err_cnt width

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
- clear, in, 1, synchronous clear of err_vec, err_cnt, first_err, first_vld
- AWID/AWADDR/AWLEN/AWSIZE[3]/AWBURST[2]/AWVALID/AWREADY, in, write address channel
- WID/WDATA/WSTRB/WLAST/WVALID/WREADY, in, write data channel
- BID/BRESP[2]/BVALID/BREADY, in, write response channel
- ARID/ARADDR/ARLEN/ARSIZE[3]/ARBURST[2]/ARVALID/ARREADY, in, read address channel
- RID/RDATA/RRESP[2]/RLAST/RVALID/RREADY, in, read data channel
- err_vec, out, 15, sticky violation flags (bit map below)
- err_pulse, out, 1, high for one cycle per cycle containing ≥1 new violation
- err_cnt, out, CNT_W, count of err_pulse cycles, saturating at all-ones
- first_err, out, 4, index of lowest set bit among the first violating cycle
- first_vld, out, 1, first_err valid
- wr_out, out, log2(MAX_OUT)+1, AW bursts awaiting BRESP
- rd_out, out, log2(MAX_OUT)+1, AR bursts awaiting RLAST

## Operation
err_vec bit map:
- 0–4: stability violations on AW, W, B, AR, R.
- 5–9: timeouts on AW, W, B, AR, R.
- 10: WLEN mismatch.
- 11: orphan B.
- 12: RLEN mismatch.
- 13: orphan R.
- 14: outstanding overflow.

Checks:
- Stability, per channel: a cycle with VALID=1 and READY=0 is followed by VALID=0 or any payload change.
  - AW payload: ID, ADDR, LEN, SIZE, BURST.
  - W payload: ID, DATA, STRB, LAST.
  - B payload: ID, RESP.
  - AR payload: same fields as AW.
  - R payload: ID, DATA, RESP, LAST.
  - Violation sets the channel's stability bit.
- Timeout, per channel: a counter increments while VALID=1 and READY=0, and zeroes on handshake or VALID=0. Reaching TIMEOUT sets the channel's timeout bit once per stall; the counter holds until the stall ends.
- AW FIFO (MAX_OUT entries of AWLEN): each AW handshake pushes one entry.
- W FIFO (MAX_OUT entries of LEN_W+1 bits): a W beat counter increments per W handshake, saturating. A WLAST handshake pushes beat count+1 and zeroes the counter.
- Write pairing: whenever both FIFOs are non-empty, pop both in the same cycle.
  - If W count ≠ AWLEN+1: set bit 10.
  - Either way, increment wr_out.
- B handshake: decrements wr_out; if wr_out=0, set bit 11 and leave wr_out at 0.
- AR FIFO (MAX_OUT entries of ARLEN): each AR handshake pushes one entry and increments rd_out.
- R beat handling, with the AR FIFO non-empty:
  - Each R handshake increments the beat counter.
  - If RLAST=1 and count+1 ≠ head+1: set bit 12.
  - If count+1 = head+1 and RLAST=0: set bit 12; popping still waits for RLAST.
  - An RLAST handshake pops the AR FIFO, decrements rd_out and zeroes the counter.
- R handshake with the AR FIFO empty: set bit 13; no state change.
- Overflow: a push into a full FIFO (AW, W or AR) with no pop in the same cycle sets bit 14 and drops the push. Push and pop in the same cycle on a full FIFO is legal.
- Error reporting:
  - Any new violation sets err_pulse and err_cnt+1.
  - If first_vld=0, load first_err and set first_vld.
  - clear in the same cycle as a new violation: clear first, then record the new violation.

## Timing
- All inputs are sampled at posedge clk.
- A violation sampled at edge n appears on err_vec, err_pulse and err_cnt after edge n (1-cycle latency).
- A stability check at edge n compares against the payload/valid registered at edge n-1.
- Timeout fires at the edge where the stall count reaches TIMEOUT: stall cycles 1..TIMEOUT, flag after edge TIMEOUT.
- FIFO pairing and its mismatch flag are evaluated in the cycle both heads are valid, one cycle after the later push.
- rst low asynchronously clears all outputs, FIFOs, counters and previous-sample registers (prev VALID=0). No false stability flag is raised in the first cycle after deassertion. Reset mid-burst discards all tracking state.

## Test plan
- AWVALID=1, AWREADY=0, AWADDR changes 0x100→0x104 next cycle → err_vec[0]=1, err_pulse one cycle, err_cnt=1, first_err=0.
- ARVALID held 256 cycles with ARREADY=0 (TIMEOUT=256) → err_vec[8]=1 after cycle 256 only; a 255-cycle stall → no flag.
- AWLEN=3, then 4 W beats with WLAST on beat 4, then B → no error, wr_out 1→0. Repeat with WLAST on beat 3 → err_vec[10]=1.
- W burst before AW (WLAST beat 2, AW later with AWLEN=1) → no error. B with wr_out=0 → err_vec[11]=1.
- ARLEN=1: R beat 2 with RLAST=0 → err_vec[12]. R handshake with no AR pending → err_vec[13].
- 9 AR pushes, no R, MAX_OUT=8 → err_vec[14]=1, rd_out=8. Assert rst low mid-burst → all outputs 0. clear coincident with a new violation → only the new bit set, err_cnt=1.

Source files
------------

// File: rtl/axi_protocol_checker_if.sv
// AXI3 link bundle watched by axi_protocol_checker; master/slave modports for the
// endpoints and an all-input monitor modport for passive observers.
interface axi_protocol_checker_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [LEN_W-1:0]    ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
    );

    modport monitor (
        input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWREADY,
        input WID, WDATA, WSTRB, WLAST, WVALID, WREADY,
        input BID, BRESP, BVALID, BREADY,
        input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY,
        input RID, RDATA, RRESP, RLAST, RVALID, RREADY
    );
endinterface

// File: rtl/axi_protocol_checker.sv
// Passive AXI3 protocol checker: stability, timeout, burst-length and outstanding
// tracking on all five channels, reported as sticky flags plus a counted event pulse.
module axi_pc_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic [PTR_W:0]   cnt;
    logic             full, do_push, do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (PTR_W+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign dout     = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

module axi_protocol_checker #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int MAX_OUT = 8,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    axi_protocol_checker_if.monitor  bus,
    output logic [14:0]              err_vec,
    output logic                     err_pulse,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [3:0]               first_err,
    output logic                     first_vld,
    output logic [$clog2(MAX_OUT):0] wr_out,
    output logic [$clog2(MAX_OUT):0] rd_out
);
    localparam int OUT_W = $clog2(MAX_OUT) + 1;
    localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int A_PW  = ID_W + ADDR_W + LEN_W + 5;
    localparam int W_PW  = ID_W + DATA_W + DATA_W/8 + 1;
    localparam int B_PW  = ID_W + 2;
    localparam int R_PW  = ID_W + DATA_W + 3;
    localparam int PW1   = (A_PW > W_PW) ? A_PW : W_PW;
    localparam int PW2   = (B_PW > R_PW) ? B_PW : R_PW;
    localparam int PW    = (PW1 > PW2) ? PW1 : PW2;

    // Channel order everywhere below: 0 AW, 1 W, 2 B, 3 AR, 4 R.
    logic [4:0]    vld, rdy, hs, stall;
    logic [PW-1:0] pay      [5];
    logic [PW-1:0] prev_pay [5];
    logic [4:0]    prev_vld, prev_rdy;
    logic [TO_W-1:0] to_cnt [5];
    logic [4:0]    stab_err, to_err;

    always_comb begin
        vld    = {bus.RVALID, bus.ARVALID, bus.BVALID, bus.WVALID, bus.AWVALID};
        rdy    = {bus.RREADY, bus.ARREADY, bus.BREADY, bus.WREADY, bus.AWREADY};
        hs     = vld & rdy;
        stall  = vld & ~rdy;
        pay[0] = PW'({bus.AWID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST});
        pay[1] = PW'({bus.WID, bus.WDATA, bus.WSTRB, bus.WLAST});
        pay[2] = PW'({bus.BID, bus.BRESP});
        pay[3] = PW'({bus.ARID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST});
        pay[4] = PW'({bus.RID, bus.RDATA, bus.RRESP, bus.RLAST});
        stab_err = '0;
        to_err   = '0;
        for (int i = 0; i < 5; i++) begin
            stab_err[i] = prev_vld[i] && !prev_rdy[i] && (!vld[i] || pay[i] != prev_pay[i]);
            to_err[i]   = (TIMEOUT != 0) && stall[i] && (to_cnt[i] == TO_W'(TIMEOUT - 1));
        end
    end

    // Previous-sample registers and stall counters; counters park at TIMEOUT so
    // a long stall flags only once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_vld <= '0;
            prev_rdy <= '0;
            for (int i = 0; i < 5; i++) begin
                prev_pay[i] <= '0;
                to_cnt[i]   <= '0;
            end
        end else begin
            prev_vld <= vld;
            prev_rdy <= rdy;
            for (int i = 0; i < 5; i++) begin
                prev_pay[i] <= pay[i];
                if (stall[i] && TIMEOUT != 0) begin
                    if (to_cnt[i] != TO_W'(TIMEOUT)) to_cnt[i] <= to_cnt[i] + 1'b1;
                end else begin
                    to_cnt[i] <= '0;
                end
            end
        end
    end

    logic [LEN_W:0]   w_cnt, w_next, r_cnt, r_beat, r_tgt;
    logic [LEN_W-1:0] aw_dout, ar_dout;
    logic [LEN_W:0]   w_dout;
    logic aw_empty, w_empty, ar_empty, aw_ovf, w_ovf, ar_ovf;
    logic pair, wlen_err, orphan_b, wr_inc, wr_dec;
    logic r_act, r_pop, rlen_err, orphan_r, ar_acc;

    always_comb begin
        w_next   = (&w_cnt) ? w_cnt : w_cnt + 1'b1;
        pair     = !aw_empty && !w_empty;
        wlen_err = pair && (w_dout != (LEN_W+1)'(aw_dout) + (LEN_W+1)'(1));
        orphan_b = hs[2] && (wr_out == '0);
        wr_inc   = pair && !(&wr_out);
        wr_dec   = hs[2] && (wr_out != '0);
        r_beat   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        r_tgt    = (LEN_W+1)'(ar_dout) + (LEN_W+1)'(1);
        r_act    = hs[4] && !ar_empty;
        r_pop    = r_act && bus.RLAST;
        rlen_err = r_act && ((bus.RLAST && r_beat != r_tgt) || (!bus.RLAST && r_beat == r_tgt));
        orphan_r = hs[4] && ar_empty;
        ar_acc   = hs[3] && !ar_ovf;
    end

    axi_pc_fifo #(.W(LEN_W), .DEPTH(MAX_OUT)) u_aw_fifo (
        .clk(clk), .rst(rst), .push(hs[0]), .pop(pair), .din(bus.AWLEN),
        .dout(aw_dout), .empty(aw_empty), .overflow(aw_ovf)
    );

    axi_pc_fifo #(.W(LEN_W+1), .DEPTH(MAX_OUT)) u_w_fifo (
        .clk(clk), .rst(rst), .push(hs[1] && bus.WLAST), .pop(pair), .din(w_next),
        .dout(w_dout), .empty(w_empty), .overflow(w_ovf)
    );

    axi_pc_fifo #(.W(LEN_W), .DEPTH(MAX_OUT)) u_ar_fifo (
        .clk(clk), .rst(rst), .push(hs[3]), .pop(r_pop), .din(bus.ARLEN),
        .dout(ar_dout), .empty(ar_empty), .overflow(ar_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_cnt  <= '0;
            r_cnt  <= '0;
            wr_out <= '0;
            rd_out <= '0;
        end else begin
            if (hs[1]) w_cnt <= bus.WLAST ? '0 : w_next;
            if (r_pop)      r_cnt <= '0;
            else if (r_act) r_cnt <= r_beat;
            wr_out <= wr_out + OUT_W'(wr_inc) - OUT_W'(wr_dec);
            rd_out <= rd_out + OUT_W'(ar_acc) - OUT_W'(r_pop);
        end
    end

    logic [14:0]      new_err;
    logic [CNT_W-1:0] cnt_base;

    function automatic logic [3:0] lowest_bit(input logic [14:0] v);
        lowest_bit = 4'd0;
        for (int i = 14; i >= 0; i--) if (v[i]) lowest_bit = 4'(i);
    endfunction

    always_comb begin
        new_err  = {aw_ovf | w_ovf | ar_ovf, orphan_r, rlen_err, orphan_b, wlen_err, to_err, stab_err};
        cnt_base = clear ? '0 : err_cnt;
    end

    // clear acts before this cycle's violations are recorded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_vec   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
            first_vld <= 1'b0;
        end else begin
            err_vec   <= (clear ? 15'd0 : err_vec) | new_err;
            err_pulse <= |new_err;
            err_cnt   <= ((|new_err) && !(&cnt_base)) ? cnt_base + 1'b1 : cnt_base;
            if ((|new_err) && (clear || !first_vld)) begin
                first_err <= lowest_bit(new_err);
                first_vld <= 1'b1;
            end else if (clear) begin
                first_err <= '0;
                first_vld <= 1'b0;
            end
        end
    end
endmodule
